// File: rtl/sent_rx_crc_check.sv
// sent_rx_crc_check
//   Receive-side SENT CRC4 checker. Takes the data nibbles (MSN first) and the
//   trailing CRC nibble of one fast-channel frame. Recomputes the CRC4 with
//   seed 4'b0101 and polynomial x^4+x^3+x^2+1. Reports a one-cycle verdict.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high
//   start        in   frame start pulse, samples frame_len
//   frame_len    in   3  number of data nibbles (legal 1..6)
//   nibble_valid in   nibble carries a decoded nibble this cycle
//   nibble       in   4  data nibble, or the CRC nibble after the last data nibble
//   frame_abort  in   drop the frame in progress and clear the held verdict
//   busy         out  frame in progress (DATA or CHECK)
//   crc_done     out  one-cycle pulse, verdict valid
//   crc_ok       out  received CRC matched (held until next accepted start)
//   crc_err      out  received CRC differed (held until next accepted start)
//   crc_calc     out  4  computed CRC (held until next accepted start)
//   len_err      out  one-cycle pulse, start rejected for frame_len 0 or 7
module sent_rx_crc_check (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] frame_len,
  input  logic       nibble_valid,
  input  logic [3:0] nibble,
  input  logic       frame_abort,
  output logic       busy,
  output logic       crc_done,
  output logic       crc_ok,
  output logic       crc_err,
  output logic [3:0] crc_calc,
  output logic       len_err
);

  localparam logic [3:0] SEED = 4'b0101;
  localparam logic [3:0] POLY = 4'b1101;  // x^4 term implicit

  typedef enum logic [1:0] {IDLE, DATA, CHECK} state_t;

  state_t     state, state_n;
  logic [3:0] r, r_n;
  logic [2:0] cnt, cnt_n;
  logic [2:0] len, len_n;
  logic       done_n, ok_n, err_n, len_err_n;
  logic [3:0] calc_n;
  logic [3:0] r_shift;
  logic       len_legal;

  // Multiply the remainder by z^4 modulo the generator.
  function automatic logic [3:0] crc_t(input logic [3:0] x);
    logic [3:0] v;
    v = x;
    for (int unsigned i = 0; i < 4; i++) begin
      v = v[3] ? ({v[2:0], 1'b0} ^ POLY) : {v[2:0], 1'b0};
    end
    return v;
  endfunction

  assign r_shift   = crc_t(r);
  assign len_legal = (frame_len != 3'd0) && (frame_len != 3'd7);

  always_comb begin
    state_n   = state;
    r_n       = r;
    cnt_n     = cnt;
    len_n     = len;
    done_n    = 1'b0;
    len_err_n = 1'b0;
    ok_n      = crc_ok;
    err_n     = crc_err;
    calc_n    = crc_calc;

    if (frame_abort) begin
      state_n = IDLE;
      r_n     = SEED;
      cnt_n   = '0;
      ok_n    = 1'b0;
      err_n   = 1'b0;
      calc_n  = '0;
    end else if (start) begin
      // A start always claims the cycle, so a coincident nibble is dropped
      // whether or not the length turns out to be legal.
      if (len_legal) begin
        state_n = DATA;
        len_n   = frame_len;
        r_n     = SEED;
        cnt_n   = '0;
        ok_n    = 1'b0;
        err_n   = 1'b0;
        calc_n  = '0;
      end else begin
        len_err_n = 1'b1;
      end
    end else if (nibble_valid) begin
      case (state)
        DATA: begin
          r_n   = r_shift ^ nibble;
          cnt_n = cnt + 3'd1;
          if (cnt + 3'd1 == len) state_n = CHECK;
        end
        CHECK: begin
          calc_n  = r_shift;
          ok_n    = (nibble == r_shift);
          err_n   = (nibble != r_shift);
          done_n  = 1'b1;
          state_n = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      r        <= SEED;
      cnt      <= '0;
      len      <= '0;
      crc_done <= 1'b0;
      crc_ok   <= 1'b0;
      crc_err  <= 1'b0;
      crc_calc <= '0;
      len_err  <= 1'b0;
    end else begin
      state    <= state_n;
      r        <= r_n;
      cnt      <= cnt_n;
      len      <= len_n;
      crc_done <= done_n;
      crc_ok   <= ok_n;
      crc_err  <= err_n;
      crc_calc <= calc_n;
      len_err  <= len_err_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sent_rx_crc_check.sv
module tb_sent_rx_crc_check;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] frame_len = '0;
  logic       nibble_valid = 1'b0;
  logic [3:0] nibble = '0;
  logic       frame_abort = 1'b0;
  logic       busy, crc_done, crc_ok, crc_err, len_err;
  logic [3:0] crc_calc;

  int n_checks = 0;
  int n_errors = 0;

  sent_rx_crc_check dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .frame_len    (frame_len),
    .nibble_valid (nibble_valid),
    .nibble       (nibble),
    .frame_abort  (frame_abort),
    .busy         (busy),
    .crc_done     (crc_done),
    .crc_ok       (crc_ok),
    .crc_err      (crc_err),
    .crc_calc     (crc_calc),
    .len_err      (len_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: long division of {0101, data..., 0000} by 11101.
  function automatic logic [3:0] crc_ref(input int len, input logic [3:0] d[6]);
    logic [31:0] v;
    v = 32'h5;
    for (int i = 0; i < len; i++) v = (v << 4) | {28'd0, d[i]};
    v = v << 4;
    for (int b = 4 * len + 7; b >= 4; b--)
      if (v[b]) v = v ^ (32'h1D << (b - 4));
    return v[3:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n, input logic exp_busy);
    for (int i = 0; i < n; i++) begin
      tick();
      check("idle_busy", busy, exp_busy);
      check("idle_done", crc_done, 1'b0);
    end
  endtask

  task automatic send_nibble(input logic [3:0] n);
    nibble_valid = 1'b1;
    nibble = n;
    tick();
    nibble_valid = 1'b0;
  endtask

  task automatic do_start(input logic [2:0] len);
    start = 1'b1;
    frame_len = len;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1'b1);
    check("start_done", crc_done, 1'b0);
    check("start_ok_clr", crc_ok, 1'b0);
    check("start_err_clr", crc_err, 1'b0);
    check("start_calc_clr", crc_calc, 4'h0);
  endtask

  // Feed data + CRC with random gaps up to maxgap; check verdict on the done cycle.
  task automatic feed_frame(input int len, input logic [3:0] d[6], input logic [3:0] rx,
                            input logic [3:0] exp_calc, input int maxgap);
    for (int i = 0; i < len; i++) begin
      idle_cycles($urandom_range(maxgap, 0), 1'b1);
      send_nibble(d[i]);
      check("data_busy", busy, 1'b1);
      check("data_done", crc_done, 1'b0);
    end
    idle_cycles($urandom_range(maxgap, 0), 1'b1);
    send_nibble(rx);
    check("done_pulse", crc_done, 1'b1);
    check("done_busy", busy, 1'b0);
    check("done_calc", crc_calc, exp_calc);
    check("done_ok", crc_ok, rx == exp_calc);
    check("done_err", crc_err, rx != exp_calc);
  endtask

  task automatic run_frame(input int len, input logic [3:0] d[6], input logic [3:0] rx,
                           input logic [3:0] exp_calc, input int maxgap);
    do_start(3'(len));
    feed_frame(len, d, rx, exp_calc, maxgap);
  endtask

  logic [3:0] d200[6] = '{4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
  logic [3:0] dz[6]   = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

  initial begin
    logic [3:0] rd[6];
    int         rl;
    logic [3:0] rc;
    logic [3:0] rrx;

    #2;
    check("rst_busy", busy, 1'b0);
    check("rst_done", crc_done, 1'b0);
    check("rst_ok", crc_ok, 1'b0);
    check("rst_err", crc_err, 1'b0);
    check("rst_calc", crc_calc, 4'h0);
    check("rst_len_err", len_err, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Basic frame, back-to-back
    run_frame(3, d200, 4'h7, 4'h7, 0);
    tick();
    check("after_done", crc_done, 1'b0);
    check("held_ok", crc_ok, 1'b1);
    check("held_calc", crc_calc, 4'h7);

    // Zero-data frames; starts immediately follow the done cycle
    run_frame(3, dz, 4'h9, 4'h9, 0);
    run_frame(4, dz, 4'hC, 4'hC, 0);
    run_frame(6, dz, 4'h5, 4'h5, 0);
    run_frame(6, dz, 4'h4, 4'h5, 0);
    tick();
    check("held_err", crc_err, 1'b1);

    // Gapped stream
    run_frame(3, d200, 4'h7, 4'h7, 5);
    idle_cycles(4, 1'b0);

    // Abort in IDLE clears the held verdict
    frame_abort = 1'b1;
    tick();
    frame_abort = 1'b0;
    check("abort_idle_ok", crc_ok, 1'b0);
    check("abort_idle_calc", crc_calc, 4'h0);

    // Abort mid-frame, with a coincident start that must lose
    do_start(3'd4);
    send_nibble(4'h2);
    send_nibble(4'h0);
    frame_abort = 1'b1;
    start = 1'b1;
    frame_len = 3'd3;
    tick();
    frame_abort = 1'b0;
    start = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_ok", crc_ok, 1'b0);
    check("abort_err", crc_err, 1'b0);
    send_nibble(4'h0);
    send_nibble(4'h0);
    send_nibble(4'h7);
    check("abort_no_done", crc_done, 1'b0);
    idle_cycles(2, 1'b0);

    // Restart mid-DATA with a coincident nibble that must be dropped
    do_start(3'd3);
    send_nibble(4'h3);
    start = 1'b1;
    frame_len = 3'd3;
    nibble_valid = 1'b1;
    nibble = 4'hF;
    tick();
    start = 1'b0;
    nibble_valid = 1'b0;
    check("restart_busy", busy, 1'b1);
    feed_frame(3, d200, 4'h7, 4'h7, 1);
    tick();

    // Bad lengths: held verdict stays, nibbles ignored
    for (int k = 0; k < 2; k++) begin
      start = 1'b1;
      frame_len = (k == 0) ? 3'd0 : 3'd7;
      tick();
      start = 1'b0;
      check("len_err_pulse", len_err, 1'b1);
      check("len_err_busy", busy, 1'b0);
      check("len_err_held_ok", crc_ok, 1'b1);
      tick();
      check("len_err_clear", len_err, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      send_nibble(4'(k));
      check("badlen_no_done", crc_done, 1'b0);
      check("badlen_busy", busy, 1'b0);
    end

    // Asynchronous reset between edges while in CHECK
    do_start(3'd3);
    send_nibble(4'h2);
    send_nibble(4'h0);
    send_nibble(4'h0);
    check("pre_rst_busy", busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", crc_done, 1'b0);
    check("arst_calc", crc_calc, 4'h0);
    nibble_valid = 1'b1;
    nibble = 4'h7;
    tick();
    nibble_valid = 1'b0;
    check("arst_no_done", crc_done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    run_frame(3, d200, 4'h7, 4'h7, 0);
    tick();

    // Randomized frames against the long-division model
    for (int f = 0; f < 60; f++) begin
      rl = $urandom_range(6, 1);
      for (int i = 0; i < 6; i++) rd[i] = 4'($urandom);
      rc = crc_ref(rl, rd);
      rrx = ($urandom_range(1, 0) == 1) ? rc : 4'($urandom);
      run_frame(rl, rd, rrx, rc, 3);
      if ($urandom_range(1, 0) == 1) tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sent_rx_crc_check.md
# sent_rx_crc_check

Receive-side SENT CRC4 checker. Consumes the data nibbles and trailing CRC nibble of one fast-channel frame, one nibble per accepted strobe, as the SENT receive pulse decoder emits them. Recomputes the CRC4 using the same seed and polynomial as the transmit-side generator, then reports a one-cycle verdict to the receive frame assembler.

## Interface
- No parameters. The following are fixed constants: CRC seed 4'b0101, polynomial x^4+x^3+x^2+1 (5'b11101).
- clk  input  1  Single clock, rising edge.
- reset  input  1  Asynchronous, active-high.
- start  input  1  Frame start pulse; samples frame_len.
- frame_len  input  3  Number of data nibbles in the frame. Legal values 1..6.
- nibble_valid  input  1  nibble carries a decoded nibble this cycle.
- nibble  input  4  Decoded nibble: data nibbles MSN first, then the CRC nibble.
- frame_abort  input  1  Decoder detected a pulse error; drop the frame in progress.
- busy  output  1  High in DATA or CHECK.
- crc_done  output  1  One-cycle pulse: verdict valid.
- crc_ok  output  1  Received CRC equals computed CRC. Held until the next accepted start.
- crc_err  output  1  Received CRC differs from computed CRC. Held until the next accepted start.
- crc_calc  output  4  Computed CRC. Held until the next accepted start.
- len_err  output  1  One-cycle pulse: start was rejected because frame_len was 0 or 7.

## Operation
- CRC arithmetic:
  - T(x) = (x·z^4) mod g(z) on 4 bits. Equivalent to 4 iterations of: shift left 1; if the bit shifted out is 1, XOR 4'b1101.
  - Running remainder r: initialised to 4'b0101 on start; updated per data nibble as r <= T(r) ^ nibble.
  - Final CRC = T(r).
  - The result is identical to long division of {0101, data, 0000} by 11101.
- FSM states: IDLE, DATA, CHECK.
  - IDLE:
    - start with frame_len in 1..6: latch the length, set r=0101, cnt=0, clear crc_ok/crc_err/crc_calc, go to DATA.
    - start with frame_len 0 or 7: pulse len_err, stay in IDLE, leave the held outputs unchanged.
    - nibble_valid is ignored.
  - DATA: each nibble_valid updates r and increments cnt. When the accepted nibble makes cnt equal the latched length, go to CHECK.
  - CHECK: the next nibble_valid is the received CRC.
    - Register crc_calc=T(r).
    - Set crc_ok if nibble==T(r); otherwise set crc_err.
    - Pulse crc_done and return to IDLE.
- Priorities in the same cycle, highest first:
  - reset.
  - frame_abort: any state goes to IDLE, no crc_done, held outputs cleared to 0.
  - start: restarts from any state. A legal start in DATA/CHECK discards the frame in progress with no crc_done. The nibble presented in the same cycle is discarded.
  - nibble_valid.
- start and frame_abort together: frame_abort wins and start is ignored.
- crc_ok and crc_err are never both 1.

## Timing
- Reset values: state IDLE, r=0101, cnt=0, busy=0, crc_done=0, crc_ok=0, crc_err=0, crc_calc=0, len_err=0.
- start accepted at edge k: busy=1 from k+1. The first nibble is accepted at edge k+1 or later.
- One nibble is accepted per cycle; back-to-back nibble_valid is legal. Idle gaps between nibbles of any length are allowed.
- Latency: CRC nibble accepted at edge m → crc_done, crc_ok/crc_err and crc_calc are valid after edge m, for one cycle of crc_done. busy=0 from that same edge.
- crc_done may be followed by a start in the very next cycle.
- len_err: asserted the cycle after the rejected start, for 1 cycle.
- Asynchronous reset mid-frame: all outputs are immediately forced to their reset values, with no crc_done.

## Test plan
- 3-nibble frame: start, frame_len=3, nibbles 2,0,0, CRC 7 back-to-back → crc_done 1 cycle after the CRC nibble, crc_ok=1, crc_err=0, crc_calc=7.
- Zero-data frames: 3×0 with CRC 9; 4×0 with CRC C; 6×0 with CRC 5 → crc_ok=1 and crc_calc 9/C/5 respectively. Repeat 6×0 with CRC 4 → crc_err=1, crc_calc=5.
- Gapped stream: frame 2,0,0,7 with 0–5 idle cycles between nibbles → same verdict; busy stays high throughout; crc_done exactly once.
- Abort/restart:
  - frame_abort after 2 of 4 data nibbles → no crc_done, outputs 0, IDLE.
  - start mid-DATA with a simultaneous nibble_valid → that nibble is dropped; the new frame 2,0,0,7 passes.
- Bad length: start with frame_len=0, then with 7 → len_err pulse each time, busy stays 0. Subsequent nibbles are ignored with no crc_done.
- Asynchronous reset asserted between clock edges during CHECK → outputs go to reset values immediately. After release, frame 2,0,0,7 passes normally.
